uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, in parallel with the data RAM. It uses the same ce/we/addr/sel/data_i/data_o port set the core drives toward data RAM. The external address decode asserts ce for this block's 16-byte window. Bytes written by the core go into a TX FIFO and are serialized 8N1, LSB first, on txd_o at a programmable baud divisor.

Parameters:
CLK_DIV, 868, reset value of the DIV register (clock cycles per bit).
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high (1 = reset).
ce  in  1  chip enable from the bus decode; access valid only when 1.
we  in  1  1 = write, 0 = read.
addr  in  32  byte address; only addr[3:2] is decoded.
sel  in  4  byte-lane selects.
data_i  in  32  write data from the core.
data_o  out  32  read data to the core.
txd_o  out  1  serial output; idles high.
irq_o  out  1  level interrupt, transmit complete.

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: write pushes data_i[7:0] into the FIFO; reads return 0.
  - 1 STATUS, read-only except bit3:
    - bit0 busy (state != IDLE).
    - bit1 fifo_full.
    - bit2 fifo_empty.
    - bit3 overrun, sticky; write 1 clears it, write 0 leaves it.
    - bits[7:4] fifo count, saturated at 15.
    - other bits read 0.
  - 2 CTRL: bit0 tx_en (reset 1), bit1 irq_en (reset 0); other bits read 0.
  - 3 DIV: bits[15:0] divisor (reset CLK_DIV); other bits read 0.
- Writes take effect at the rising edge where ce=1, we=1 and sel=4'b1111. Any other sel value makes the write a no-op.
- Reads are combinational, with zero-latency data_o: the addressed register when ce=1 and we=0, else 32'h0. sel is ignored on reads.
- Effective divisor = max(DIV, 2).
- FIFO behaviour:
  - A push to TXDATA when full (and with no pop in the same cycle) is dropped and sets overrun.
  - If a push and a pop happen in the same cycle, both are performed; when full, the push is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Transmit state machine:
  - States: IDLE, START, DATA, STOP.
  - IDLE -> START at a rising edge when the FIFO is non-empty and tx_en=1. That edge pops the head byte into the shift register, loads the bit counter with the effective divisor minus 1, and drives txd_o=0.
  - Each state holds txd_o for exactly effective-divisor cycles. The bit counter counts down to 0 and is reloaded at each bit boundary.
  - START -> DATA: txd_o = shift[0]. DATA emits bits 0..7, shifting right; after bit 7 it goes to STOP with txd_o=1.
  - At the end of STOP: if the FIFO is non-empty and tx_en=1, go directly to START, popping the next byte back-to-back with no idle cycle. Otherwise go to IDLE.
  - A frame lasts 10 x effective divisor cycles.
- Write-to-line latency: for a TXDATA write sampled at edge N with the FIFO empty and the FSM in IDLE, txd_o falls after edge N+1.
- Clearing tx_en does not abort the current frame; it only stops further pops.
- A DIV write applies from the next counter reload; the current bit keeps its original length.
- txd_o is registered, so the line has no glitches.
- irq_o = irq_en & fifo_empty & (state == IDLE), registered, so it updates one cycle after the condition changes.
- Reset (rst=1 at an edge), including mid-frame:
  - FSM to IDLE; txd_o=1 and irq_o=0 on the following cycle.
  - FIFO emptied (count 0); overrun cleared.
  - tx_en=1, irq_en=0, DIV=CLK_DIV.
  - data_o follows the read rules with the reset register values.
- A bus access during rst=1 is ignored.

Test Plan:
1. Reset defaults -> txd_o=1, irq_o=0; reading STATUS gives 32'h00000004; CTRL gives 32'h1; DIV gives CLK_DIV.
2. DIV=4, write TXDATA=32'hA5 at edge N -> txd_o falls after edge N+1. The line then carries 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. The FSM returns to IDLE 40 cycles after START.
3. tx_en=0, write 9 bytes 0x01..0x09 -> STATUS reads full=1, count=8, overrun=1. Then set tx_en=1 -> 8 frames 0x01..0x08 back-to-back with no idle cycle between them (80 x DIV cycles); byte 0x09 is never sent.
4. Write TXDATA with sel=4'b0001 -> FIFO unchanged and no transmission. Write 1 to STATUS bit3 -> overrun reads 0.
5. Set irq_en=1, send one byte -> irq_o=0 during the frame and 1 one cycle after the FSM reaches IDLE. Write DIV=0 -> bits last 2 cycles.
6. Assert rst for 1 cycle during DATA bit 3 -> txd_o=1 on the next cycle and stays high. FIFO count 0. DIV reads CLK_DIV.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the CPU data bus.
// Zero-latency combinational reads; a push to a full FIFO is dropped and flagged as overrun.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overrun;
  logic            r_tx_en;
  logic            r_irq_en;
  logic [15:0]     r_div;
  logic [15:0]     r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic            r_irq;

  logic            w_wr_en;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_can_start;
  logic            w_bit_end;
  logic            w_busy;
  logic [15:0]     w_div_eff;
  logic [15:0]     w_reload;
  logic [31:0]     w_cnt32;
  logic [3:0]      w_cnt_sat;
  logic [7:0]      w_head;
  logic            w_unused;

  assign w_unused = &{1'b0, addr[31:4], addr[1:0], data_i[31:16]};

  assign w_wr_en     = ce & we & (sel == 4'b1111) & ~rst;
  assign w_push_req  = w_wr_en & (addr[3:2] == 2'd0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_can_start = ~w_empty & r_tx_en;
  assign w_bit_end   = (r_cnt == 16'd0);
  assign w_div_eff   = (r_div < 16'd2) ? 16'd2 : r_div;
  assign w_reload    = w_div_eff - 16'd1;
  assign w_cnt32     = 32'(r_count);
  assign w_cnt_sat   = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];

  // FIFO storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_tx_en   <= 1'b1;
      r_irq_en  <= 1'b0;
      r_div     <= 16'(CLK_DIV);
    end else begin
      if (w_wr_en && addr[3:2] == 2'd2) begin
        r_tx_en  <= data_i[0];
        r_irq_en <= data_i[1];
      end
      if (w_wr_en && addr[3:2] == 2'd3) r_div <= data_i[15:0];
      if (w_push_req && w_full && !w_pop) r_overrun <= 1'b1;
      else if (w_wr_en && addr[3:2] == 2'd1 && data_i[3]) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_can_start) w_next_state = S_START;
      S_START: if (w_bit_end) w_next_state = S_DATA;
      S_DATA:  if (w_bit_end && r_bit == 3'd7) w_next_state = S_STOP;
      S_STOP:  if (w_bit_end) w_next_state = w_can_start ? S_START : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_pop  = w_can_start & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  end

  // Bit timing: r_cnt counts down one bit period; DIV changes only take hold at a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd   <= 1'b1;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else if (w_pop) begin
      r_shift <= w_head;
      r_cnt   <= w_reload;
      r_txd   <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_cnt <= r_cnt - 16'd1;
      end else begin
        r_cnt <= w_reload;
        case (r_state)
          S_START: begin
            r_txd <= r_shift[0];
            r_bit <= 3'd0;
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_txd <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end
          default: r_cnt <= 16'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
  end

  assign txd_o = r_txd;
  assign irq_o = r_irq;

  always_comb begin
    data_o = 32'h0;
    if (ce && !we) begin
      case (addr[3:2])
        2'd1:    data_o = {24'h0, w_cnt_sat, r_overrun, w_empty, w_full, w_busy};
        2'd2:    data_o = {30'h0, r_irq_en, r_tx_en};
        2'd3:    data_o = {16'h0, r_div};
        default: data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, frame timing, FIFO overrun, irq and reset.
module tb_uart_tx_mmio;

  localparam int CLK_DIV = 868;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        txd_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_mmio #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd_o(txd_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    ce = 1'b1; we = 1'b1; addr = {28'h1000002, a, 2'b00}; data_i = d; sel = s;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = {28'h1000002, a, 2'b00}; sel = 4'h0;
    #1;
    d = data_o;
    ce = 1'b0;
  endtask

  // Walks one frame from the first start-bit cycle, checking every cycle of the line.
  task automatic check_frame(input logic [7:0] b, input int div, input string tag, input logic irq_low);
    logic lvl;
    for (int k = 0; k < 10; k++) begin
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < div; c++) begin
        check($sformatf("%s_b%0d_c%0d", tag, k, c), {31'h0, txd_o}, {31'h0, lvl});
        if (irq_low) check($sformatf("%s_irq_b%0d", tag, k), {31'h0, irq_o}, 32'h0);
        cyc();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // 1: reset defaults
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_txd", {31'h0, txd_o}, 32'h1);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    bus_rd(2'd1, rd); check("rst_status", rd, 32'h4);
    bus_rd(2'd2, rd); check("rst_ctrl", rd, 32'h1);
    bus_rd(2'd3, rd); check("rst_div", rd, CLK_DIV);
    bus_rd(2'd0, rd); check("rd_txdata_zero", rd, 32'h0);
    ce = 1'b0; addr = 32'h4; #1;
    check("no_ce_zero", data_o, 32'h0);

    // 2: single frame 0xA5 at DIV=4
    bus_wr(2'd3, 32'hFFFF_0004, 4'hF);
    bus_rd(2'd3, rd); check("div_wr", rd, 32'h4);
    bus_wr(2'd0, 32'h0000_00A5, 4'hF);
    check("t2_latency_hi", {31'h0, txd_o}, 32'h1);
    cyc();
    check_frame(8'hA5, 4, "t2", 1'b1);
    bus_rd(2'd1, rd); check("t2_idle_status", rd, 32'h4);

    // 3: overrun with tx disabled, then eight back-to-back frames
    bus_wr(2'd2, 32'h0, 4'hF);
    for (int i = 1; i <= 9; i++) bus_wr(2'd0, i, 4'hF);
    bus_rd(2'd1, rd); check("t3_full_status", rd, 32'h8A);
    check("t3_no_tx", {31'h0, txd_o}, 32'h1);
    bus_wr(2'd2, 32'h1, 4'hF);
    check("t3_latency_hi", {31'h0, txd_o}, 32'h1);
    cyc();
    for (int f = 0; f < 8; f++) check_frame(8'(f + 1), 4, $sformatf("t3_f%0d", f), 1'b0);
    bus_rd(2'd1, rd); check("t3_done_status", rd, 32'h0C);
    for (int i = 0; i < 20; i++) begin
      check("t3_byte9_not_sent", {31'h0, txd_o}, 32'h1);
      cyc();
    end

    // 4: partial-sel write is a no-op; overrun write-1-to-clear
    bus_wr(2'd0, 32'h55, 4'b0001);
    bus_rd(2'd1, rd); check("t4_sel_noop_status", rd, 32'h0C);
    for (int i = 0; i < 10; i++) begin
      check("t4_sel_noop_line", {31'h0, txd_o}, 32'h1);
      cyc();
    end
    bus_wr(2'd1, 32'h0, 4'hF);
    bus_rd(2'd1, rd); check("t4_w0_keeps_ovr", rd, 32'h0C);
    bus_wr(2'd1, 32'h8, 4'hF);
    bus_rd(2'd1, rd); check("t4_w1_clears_ovr", rd, 32'h04);

    // 5: irq behaviour and minimum divisor
    bus_wr(2'd2, 32'h3, 4'hF);
    check("t5_irq_lag", {31'h0, irq_o}, 32'h0);
    cyc();
    check("t5_irq_set", {31'h0, irq_o}, 32'h1);
    bus_wr(2'd3, 32'h0, 4'hF);
    bus_wr(2'd0, 32'h3C, 4'hF);
    check("t5_irq_still_hi", {31'h0, irq_o}, 32'h1);
    cyc();
    check_frame(8'h3C, 2, "t5", 1'b1);
    bus_rd(2'd1, rd); check("t5_idle_status", rd, 32'h04);
    check("t5_irq_lag_end", {31'h0, irq_o}, 32'h0);
    cyc();
    check("t5_irq_back", {31'h0, irq_o}, 32'h1);

    // 6: reset mid-frame during DATA bit 3, with a concurrent bus write
    bus_wr(2'd3, 32'h4, 4'hF);
    bus_wr(2'd0, 32'h00, 4'hF);
    bus_wr(2'd0, 32'h11, 4'hF);
    bus_wr(2'd0, 32'h22, 4'hF);
    repeat (15) cyc();
    check("t6_in_bit3", {31'h0, txd_o}, 32'h0);
    bus_rd(2'd1, rd); check("t6_pre_status", rd, 32'h21);
    rst = 1'b1;
    ce = 1'b1; we = 1'b1; addr = 32'h0; sel = 4'hF; data_i = 32'h77;
    cyc();
    rst = 1'b0;
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
    check("t6_txd_hi", {31'h0, txd_o}, 32'h1);
    check("t6_irq_lo", {31'h0, irq_o}, 32'h0);
    bus_rd(2'd1, rd); check("t6_status", rd, 32'h04);
    bus_rd(2'd3, rd); check("t6_div", rd, CLK_DIV);
    bus_rd(2'd2, rd); check("t6_ctrl", rd, 32'h1);
    for (int i = 0; i < 60; i++) begin
      check("t6_line_idle", {31'h0, txd_o}, 32'h1);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
